// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the core/responder interface and the responder's
// state encoding.
package dbus_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } responder_state_t;

    // The fourth size encoding is unused and treated as never aligned.
    function automatic logic is_aligned(input msize_t size, input logic [1:0] lsb);
        case (size)
            MSIZE1:  return 1'b1;
            MSIZE2:  return ~lsb[0];
            MSIZE4:  return lsb == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dbus_responder_bytemem.sv
// Word-addressed memory with per-byte write enables and an asynchronous
// full-word read port.
module bytemem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] r_mem [DEPTH];

    // NOTE: storage arrays take no reset; contents survive resetn and a reset
    // branch here would stop the array mapping onto RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                r_mem[widx][b] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = r_mem[ridx];

endmodule

// File: rtl/dbus_responder.sv
// Single-outstanding data-bus responder with fixed accept-to-data_ok latency,
// byte-strobed writes committed at accept, and misalign/range fault reporting.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       fault
);

    localparam int AW = $clog2(DEPTH);

    responder_state_t r_state;
    responder_state_t w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [31:0]      r_rdata;
    logic             r_fault;

    logic             w_addr_ok;
    logic             w_accept;
    logic             w_in_range;
    logic             w_legal;
    logic             w_data_ok;
    logic [3:0]       w_we;
    logic [AW-1:0]    w_idx;
    logic [31:0]      w_rdata;

    assign w_idx      = dreq.addr[AW+1:2];
    assign w_in_range = dreq.addr[31:AW+2] == '0;
    assign w_legal    = w_in_range && is_aligned(dreq.size, dreq.addr[1:0]);
    assign w_accept   = dreq.valid && w_addr_ok;
    assign w_we       = (w_accept && w_legal) ? dreq.strobe : 4'b0000;

    bytemem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .widx  (w_idx),
        .wdata (dreq.data),
        .ridx  (w_idx),
        .rdata (w_rdata)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_ok   = 1'b0;
        case (r_state)
            IDLE: begin
                w_addr_ok = resetn && dreq.valid;
                if (dreq.valid) begin
                    w_cnt_nxt   = 4'(LATENCY - 1);
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                // Read data is captured at accept; writes and faults return zero.
                r_rdata <= (w_legal && dreq.strobe == 4'b0000) ? w_rdata : '0;
                r_fault <= !w_legal;
            end
        end
    end

    assign w_data_ok = resetn && (r_state == RESP);
    assign dresp     = '{addr_ok: w_addr_ok,
                         data_ok: w_data_ok,
                         data:    w_data_ok ? r_rdata : 32'h0};
    assign fault     = w_data_ok && r_fault;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: two instances (LATENCY 2 and 3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    dbus_req_t  req  [2];
    dbus_resp_t resp [2];
    logic       flt  [2];

    dbus_responder #(.DEPTH(1024), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .resetn(resetn), .dreq(req[0]), .dresp(resp[0]), .fault(flt[0]));
    dbus_responder #(.DEPTH(1024), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .resetn(resetn), .dreq(req[1]), .dresp(resp[1]), .fault(flt[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=no response required=response within bound", name);
    endtask

    // Transaction-level model: an outstanding flag, the cycle its data_ok is
    // due, the word it will return, and a plain word array per instance.
    bit          busy      [2];
    int          due       [2];
    logic [31:0] pend_data [2];
    bit          pend_flt  [2];
    logic [31:0] mem_m     [2][1024];

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic model_accept(input int k);
        logic [31:0] a;
        int          bytes;
        bit          legal;
        int          idx;
        a     = req[k].addr;
        bytes = (req[k].size == MSIZE1) ? 1 : (req[k].size == MSIZE2) ? 2 :
                (req[k].size == MSIZE4) ? 4 : 0;
        legal = (bytes != 0) && (a % bytes == 0) && (a < 32'd4096);
        idx   = int'(a >> 2);
        pend_flt[k]  = !legal;
        pend_data[k] = 32'h0;
        if (legal) begin
            if (req[k].strobe == 4'b0000) begin
                pend_data[k] = mem_m[k][idx];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (req[k].strobe[b]) mem_m[k][idx][8*b +: 8] = req[k].data[8*b +: 8];
                end
            end
        end
        busy[k] = 1'b1;
        due[k]  = cyc + lat_of(k);
    endtask

    logic        e_aok, e_dok, e_flt;
    logic [31:0] e_data;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                e_aok = 1'b0; e_dok = 1'b0; e_flt = 1'b0; e_data = 32'h0;
                busy[k] = 1'b0;
            end else begin
                e_dok  = busy[k] && (cyc == due[k]);
                e_aok  = !busy[k] && req[k].valid;
                e_data = e_dok ? pend_data[k] : 32'h0;
                e_flt  = e_dok && pend_flt[k];
            end
            check($sformatf("addr_ok[%0d]@%0d", k, cyc), {31'b0, resp[k].addr_ok}, {31'b0, e_aok});
            check($sformatf("data_ok[%0d]@%0d", k, cyc), {31'b0, resp[k].data_ok}, {31'b0, e_dok});
            check($sformatf("data[%0d]@%0d", k, cyc), resp[k].data, e_data);
            check($sformatf("fault[%0d]@%0d", k, cyc), {31'b0, flt[k]}, {31'b0, e_flt});
            if (resetn) begin
                if (e_dok) busy[k] = 1'b0;
                else if (e_aok) model_accept(k);
            end
        end
    end

    task automatic wait_accept(input int k, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (resp[k].addr_ok === 1'b1) return;
            n++;
            if (n > 20) begin
                fail($sformatf("accept_timeout[%0d]", k));
                n = -1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_dok(input int k, output logic [31:0] rd, output logic fl, output int n);
        n = 0; rd = 32'h0; fl = 1'b0;
        forever begin
            @(negedge clk);
            if (resp[k].data_ok === 1'b1) begin
                rd = resp[k].data;
                fl = flt[k];
                return;
            end
            n++;
            if (n > 20) begin
                fail($sformatf("data_ok_timeout[%0d]", k));
                n = -1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    // One transaction: valid held until accepted, then dropped with scrambled
    // fields while the response is pending.
    task automatic xact(input int k, input logic [31:0] addr, input msize_t sz,
                        input logic [3:0] strb, input logic [31:0] wd,
                        output logic [31:0] rd, output logic fl, output int lat, output int wn);
        int t0;
        int n;
        rd = 32'h0; fl = 1'b0; lat = -1;
        @(posedge clk); #1;
        req[k] = '{valid: 1'b1, addr: addr, size: sz, strobe: strb, data: wd};
        wait_accept(k, wn);
        t0 = cyc;
        if (wn < 0) begin
            req[k].valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req[k] = '{valid: 1'b0, addr: $urandom, size: MSIZE1, strobe: 4'($urandom), data: $urandom};
        wait_dok(k, rd, fl, n);
        if (n >= 0) lat = cyc - t0;
    endtask

    task automatic expect_xact(input string name, input int k, input logic [31:0] addr,
                               input msize_t sz, input logic [3:0] strb, input logic [31:0] wd,
                               input logic [31:0] exp_data, input logic exp_flt);
        logic [31:0] rd;
        logic        fl;
        int          lat;
        int          wn;
        xact(k, addr, sz, strb, wd, rd, fl, lat, wn);
        check({name, "_data"}, rd, exp_data);
        check({name, "_fault"}, {31'b0, fl}, {31'b0, exp_flt});
        check({name, "_latency"}, lat, lat_of(k));
        check({name, "_accept_wait"}, wn, 0);
    endtask

    bit          aok [8];
    bit          dok [8];
    logic [31:0] dd  [8];
    int          wn;

    initial begin
        // Valid presented during reset must not be acknowledged.
        req[0] = '{valid: 1'b1, addr: 32'h10, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        req[1] = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_addr_ok", {31'b0, resp[0].addr_ok}, 32'h0);
        check("reset_data_ok", {31'b0, resp[0].data_ok}, 32'h0);
        check("reset_data", resp[0].data, 32'h0);
        check("reset_fault", {31'b0, flt[0]}, 32'h0);
        @(posedge clk); #1;
        req[0] = '0;
        resetn = 1'b1;

        // Full-word write/read, partial strobes, misalignment and range on LATENCY=2.
        expect_xact("w10",    0, 32'h10,   MSIZE4, 4'hF,    32'hDEADBEEF, 32'h0,        1'b0);
        expect_xact("r10",    0, 32'h10,   MSIZE4, 4'h0,    32'h0,        32'hDEADBEEF, 1'b0);
        expect_xact("w20",    0, 32'h20,   MSIZE4, 4'hF,    32'h11223344, 32'h0,        1'b0);
        expect_xact("w21b",   0, 32'h21,   MSIZE1, 4'b0010, 32'h0000AA00, 32'h0,        1'b0);
        expect_xact("r20",    0, 32'h20,   MSIZE4, 4'h0,    32'h0,        32'h1122AA44, 1'b0);
        expect_xact("w22mis", 0, 32'h22,   MSIZE4, 4'hF,    32'hFFFFFFFF, 32'h0,        1'b1);
        expect_xact("r20u",   0, 32'h20,   MSIZE4, 4'h0,    32'h0,        32'h1122AA44, 1'b0);
        expect_xact("r23mis", 0, 32'h23,   MSIZE2, 4'h0,    32'h0,        32'h0,        1'b1);
        expect_xact("r22h",   0, 32'h22,   MSIZE2, 4'h0,    32'h0,        32'h1122AA44, 1'b0);
        expect_xact("r1000",  0, 32'h1000, MSIZE4, 4'h0,    32'h0,        32'h0,        1'b1);
        expect_xact("w13b",   0, 32'h13,   MSIZE1, 4'b1000, 32'h77000000, 32'h0,        1'b0);
        expect_xact("r10b",   0, 32'h10,   MSIZE4, 4'h0,    32'h0,        32'h77ADBEEF, 1'b0);

        // Valid held continuously on LATENCY=3.
        expect_xact("l3w10",  1, 32'h10,   MSIZE4, 4'hF,    32'hCAFEF00D, 32'h0,        1'b0);
        expect_xact("l3w14",  1, 32'h14,   MSIZE4, 4'hF,    32'h0BADF00D, 32'h0,        1'b0);
        @(posedge clk); #1;
        req[1] = '{valid: 1'b1, addr: 32'h10, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            aok[i] = resp[1].addr_ok;
            dok[i] = resp[1].data_ok;
            dd[i]  = resp[1].data;
            @(posedge clk); #1;
            if (i == 0) req[1].addr = 32'h14;
        end
        req[1].valid = 1'b0;
        check("hold_accept0", {31'b0, aok[0]}, 32'h1);
        check("hold_aok1",    {31'b0, aok[1]}, 32'h0);
        check("hold_aok2",    {31'b0, aok[2]}, 32'h0);
        check("hold_aok3",    {31'b0, aok[3]}, 32'h0);
        check("hold_accept4", {31'b0, aok[4]}, 32'h1);
        check("hold_dok2",    {31'b0, dok[2]}, 32'h0);
        check("hold_dok3",    {31'b0, dok[3]}, 32'h1);
        check("hold_data3",   dd[3], 32'hCAFEF00D);
        check("hold_dok7",    {31'b0, dok[7]}, 32'h1);
        check("hold_data7",   dd[7], 32'h0BADF00D);

        // Reset during WAIT of a write: no data_ok, write stays committed.
        @(posedge clk); #1;
        req[0] = '{valid: 1'b1, addr: 32'h30, size: MSIZE4, strobe: 4'hF, data: 32'h55AA55AA};
        wait_accept(0, wn);
        @(posedge clk); #1;
        req[0].valid = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_no_data_ok", {31'b0, resp[0].data_ok}, 32'h0);
        expect_xact("r30", 0, 32'h30, MSIZE4, 4'h0, 32'h0, 32'h55AA55AA, 1'b0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
